// File: rtl/carregador_matriz.sv
// Assembles a row-major stream of signed elements into a packed 5x5 matrix (2x2..5x5 used).
// One element per accepting edge; matrix held in FULL until downstream acks.
module carregador_matriz #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [1:0]                        size_in,
  input  logic [ELEM_W-1:0]                 data_in,
  input  logic                              data_valid,
  output logic                              data_ready,
  output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] matrix_A,
  output logic [1:0]                        matrix_size,
  output logic                              matrix_valid,
  input  logic                              matrix_ack,
  output logic                              busy
);

  localparam int MAT_W = ELEM_W * MAX_DIM * MAX_DIM;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

  state_t             state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [1:0]         size_q, size_d;
  logic [MAT_W-1:0]   mat_q, mat_d;
  logic               rdy_q, rdy_d;
  logic               vld_q, vld_d;

  logic [2:0]         last_idx;
  logic [4:0]         slot;
  logic               transfer;

  assign last_idx = {1'b0, size_q} + 3'd1;
  assign slot     = ({2'b00, row_q} * 5'd5) + {2'b00, col_q};
  assign transfer = data_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    size_d  = size_q;
    mat_d   = mat_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          size_d  = size_in;
          mat_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (transfer) begin
          mat_d[int'(slot)*ELEM_W +: ELEM_W] = data_in;
          if (col_q == last_idx) begin
            col_d = '0;
            if (row_q == last_idx) begin
              row_d   = '0;
              state_d = S_FULL;
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      S_FULL: begin
        if (matrix_ack) begin
          if (start) begin
            // Back-to-back: the next load begins without passing through IDLE.
            size_d  = size_in;
            mat_d   = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d = (state_d == S_LOAD);
    vld_d = (state_d == S_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      size_q  <= '0;
      mat_q   <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      size_q  <= size_d;
      mat_q   <= mat_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign data_ready   = rdy_q;
  assign matrix_valid = vld_q;
  assign matrix_A     = mat_q;
  assign matrix_size  = size_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_carregador_matriz.sv
// Directed bench for carregador_matriz: loads of each order, gaps, hold, back-to-back, reset.
module tb_carregador_matriz;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   size_in;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         data_ready;
  logic [199:0] matrix_A;
  logic [1:0]   matrix_size;
  logic         matrix_valid;
  logic         matrix_ack;
  logic         busy;

  int           n_vec;
  int           n_miss;
  logic [7:0]   vals [25];
  logic [199:0] exp_m;
  logic [199:0] snap;
  int           edges;
  bit           early;

  carregador_matriz #(.ELEM_W(8), .MAX_DIM(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .size_in      (size_in),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .matrix_A     (matrix_A),
    .matrix_size  (matrix_size),
    .matrix_valid (matrix_valid),
    .matrix_ack   (matrix_ack),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; leaves the block in LOAD at the next falling edge.
  task automatic do_start(input logic [1:0] s);
    start   = 1'b1;
    size_in = s;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic ack_once();
    matrix_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    matrix_ack = 1'b0;
  endtask

  // Streams vals[0..cnt-1]; with gaps, data_valid drops every third cycle.
  task automatic feed(input int cnt, input bit gaps, output int n_edges, output bit seen_early);
    int   idx;
    int   c;
    logic rdy;
    idx        = 0;
    c          = 0;
    n_edges    = 0;
    seen_early = 1'b0;
    while (idx < cnt && c < 400) begin
      if (matrix_valid) seen_early = 1'b1;
      data_valid = !(gaps && (c % 3 == 2));
      data_in    = vals[idx];
      rdy        = data_ready;
      @(posedge clk);
      n_edges++;
      if (data_valid && rdy) idx++;
      @(negedge clk);
      c++;
    end
    data_valid = 1'b0;
    if (idx < cnt) chk("feed_timeout", 200'(idx), 200'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    size_in    = 2'b00;
    data_in    = 8'h00;
    data_valid = 1'b0;
    matrix_ack = 1'b0;

    #2;
    chk("rst_valid", 200'(matrix_valid), 200'(0));
    chk("rst_ready", 200'(data_ready), 200'(0));
    chk("rst_busy",  200'(busy), 200'(0));
    chk("rst_mat",   matrix_A, 200'(0));
    chk("rst_size",  200'(matrix_size), 200'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x2: 1,2,3,4 into slots 0,1,5,6; valid 5 edges after start.
    vals[0] = 8'd1; vals[1] = 8'd2; vals[2] = 8'd3; vals[3] = 8'd4;
    do_start(2'b00);
    chk("2x2_ready_in_load", 200'(data_ready), 200'(1));
    chk("2x2_busy_in_load",  200'(busy), 200'(1));
    feed(4, 1'b0, edges, early);
    chk("2x2_latency",  200'(edges + 1), 200'(5));
    chk("2x2_no_early", 200'(early), 200'(0));
    chk("2x2_valid",    200'(matrix_valid), 200'(1));
    chk("2x2_ready_lo", 200'(data_ready), 200'(0));
    exp_m = '0;
    exp_m[0*8 +: 8] = 8'd1;
    exp_m[1*8 +: 8] = 8'd2;
    exp_m[5*8 +: 8] = 8'd3;
    exp_m[6*8 +: 8] = 8'd4;
    chk("2x2_mat",  matrix_A, exp_m);
    chk("2x2_size", 200'(matrix_size), 200'(0));
    ack_once();
    chk("2x2_ack_valid", 200'(matrix_valid), 200'(0));
    chk("2x2_ack_busy",  200'(busy), 200'(0));
    chk("2x2_ack_keep",  matrix_A, exp_m);

    // Ack outside FULL must do nothing.
    ack_once();
    chk("idle_ack_busy", 200'(busy), 200'(0));

    // 4x4 negatives with gaps.
    for (int i = 0; i < 16; i++) vals[i] = 8'(-(i + 1));
    do_start(2'b10);
    feed(16, 1'b1, edges, early);
    chk("4x4_no_early", 200'(early), 200'(0));
    chk("4x4_valid",    200'(matrix_valid), 200'(1));
    exp_m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_m[(r*5+c)*8 +: 8] = 8'(-(4*r + c + 1));
    chk("4x4_mat",    matrix_A, exp_m);
    chk("4x4_slot6",  200'(matrix_A[6*8 +: 8]), 200'(8'hFA));
    chk("4x4_slot18", 200'(matrix_A[18*8 +: 8]), 200'(8'hF0));
    chk("4x4_slot4",  200'(matrix_A[4*8 +: 8]), 200'(0));
    chk("4x4_slot19", 200'(matrix_A[19*8 +: 8]), 200'(0));
    chk("4x4_size",   200'(matrix_size), 200'(2));
    ack_once();

    // 5x5 alternating signs, then hold with start asserted but no ack.
    for (int k = 0; k < 25; k++) vals[k] = (k % 2 == 1) ? 8'(-k) : 8'(k);
    do_start(2'b11);
    feed(25, 1'b0, edges, early);
    chk("5x5_latency", 200'(edges + 1), 200'(26));
    exp_m = '0;
    for (int k = 0; k < 25; k++) exp_m[k*8 +: 8] = (k % 2 == 1) ? 8'(-k) : 8'(k);
    chk("5x5_mat",  matrix_A, exp_m);
    chk("5x5_slot3",  200'(matrix_A[3*8 +: 8]), 200'(8'hFD));
    chk("5x5_slot24", 200'(matrix_A[24*8 +: 8]), 200'(8'h18));
    start   = 1'b1;
    size_in = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_mat",   matrix_A, exp_m);
      chk("hold_ready", 200'(data_ready), 200'(0));
      chk("hold_valid", 200'(matrix_valid), 200'(1));
    end
    chk("hold_size", 200'(matrix_size), 200'(3));

    // Ack and start together: straight into a 3x3 load.
    size_in    = 2'b01;
    matrix_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    matrix_ack = 1'b0;
    start      = 1'b0;
    chk("b2b_ready", 200'(data_ready), 200'(1));
    chk("b2b_valid", 200'(matrix_valid), 200'(0));
    chk("b2b_mat",   matrix_A, 200'(0));
    chk("b2b_size",  200'(matrix_size), 200'(1));

    for (int i = 0; i < 9; i++) vals[i] = 8'(10 + i);
    feed(9, 1'b0, edges, early);
    exp_m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        exp_m[(r*5+c)*8 +: 8] = 8'(10 + 3*r + c);
    chk("3x3_mat",   matrix_A, exp_m);
    chk("3x3_valid", 200'(matrix_valid), 200'(1));

    // Surplus data after completion is dropped.
    for (int i = 0; i < 5; i++) begin
      data_valid = 1'b1;
      data_in    = 8'h7F;
      @(posedge clk);
      @(negedge clk);
    end
    data_valid = 1'b0;
    chk("extra_mat",   matrix_A, exp_m);
    chk("extra_valid", 200'(matrix_valid), 200'(1));
    ack_once();

    // Asynchronous reset after 7 of 9 elements.
    for (int i = 0; i < 9; i++) vals[i] = 8'(100 + i);
    do_start(2'b01);
    feed(7, 1'b0, edges, early);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mat",   matrix_A, 200'(0));
    chk("mid_rst_ready", 200'(data_ready), 200'(0));
    chk("mid_rst_valid", 200'(matrix_valid), 200'(0));
    chk("mid_rst_busy",  200'(busy), 200'(0));
    chk("mid_rst_size",  200'(matrix_size), 200'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 200'(busy), 200'(0));

    vals[0] = 8'd5; vals[1] = 8'd6; vals[2] = 8'd7; vals[3] = 8'd8;
    do_start(2'b00);
    feed(4, 1'b0, edges, early);
    exp_m = '0;
    exp_m[0*8 +: 8] = 8'd5;
    exp_m[1*8 +: 8] = 8'd6;
    exp_m[5*8 +: 8] = 8'd7;
    exp_m[6*8 +: 8] = 8'd8;
    chk("after_rst_mat",   matrix_A, exp_m);
    chk("after_rst_valid", 200'(matrix_valid), 200'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
